// File: rtl/rs_slot_array.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_slot_array: reservation-station slot storage, CDB wakeup, issue reg    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rs_slot_array #(
    parameter int NUM_SLOTS  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NUM_SLOTS-1:0]  slot_wr,
    input  logic [OP_WIDTH-1:0]   disp_op,
    input  logic [TAG_WIDTH-1:0]  disp_dst_tag,
    input  logic                  disp_src1_rdy,
    input  logic [TAG_WIDTH-1:0]  disp_src1_tag,
    input  logic [DATA_WIDTH-1:0] disp_src1_val,
    input  logic                  disp_src2_rdy,
    input  logic [TAG_WIDTH-1:0]  disp_src2_tag,
    input  logic [DATA_WIDTH-1:0] disp_src2_val,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    output logic [NUM_SLOTS-1:0]  slot_busy,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [OP_WIDTH-1:0]   issue_op,
    output logic [DATA_WIDTH-1:0] issue_a,
    output logic [DATA_WIDTH-1:0] issue_b,
    output logic [TAG_WIDTH-1:0]  issue_dst_tag
);

    localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0]  r_busy;
    logic [NUM_SLOTS-1:0]  r_src1_rdy;
    logic [NUM_SLOTS-1:0]  r_src2_rdy;
    logic [OP_WIDTH-1:0]   r_op       [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  r_dst_tag  [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  r_src1_tag [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  r_src2_tag [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] r_src1_val [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] r_src2_val [NUM_SLOTS];

    logic                  r_issue_valid;
    logic [OP_WIDTH-1:0]   r_issue_op;
    logic [DATA_WIDTH-1:0] r_issue_a;
    logic [DATA_WIDTH-1:0] r_issue_b;
    logic [TAG_WIDTH-1:0]  r_issue_dst_tag;

    logic                  w_advance;
    logic                  w_cand_found;
    logic [SEL_W-1:0]      w_cand_idx;
    logic [NUM_SLOTS-1:0]  w_take;
    logic                  w_disp1_hit;
    logic                  w_disp2_hit;
    logic [DATA_WIDTH-1:0] w_disp1_val;
    logic [DATA_WIDTH-1:0] w_disp2_val;

    // Candidate comes from registered state only: no same-cycle wake-and-select.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_busy[i] && r_src1_rdy[i] && r_src2_rdy[i]) begin
                w_cand_found = 1'b1;
                w_cand_idx   = SEL_W'(i);
            end
        end
    end

    assign w_advance = !r_issue_valid || issue_ready;
    assign w_take    = (w_advance && w_cand_found && !flush)
                     ? (NUM_SLOTS'(1) << w_cand_idx) : '0;

    // Result arriving on the CDB in the dispatch cycle is captured directly.
    assign w_disp1_hit = cdb_valid && !disp_src1_rdy && (cdb_tag == disp_src1_tag);
    assign w_disp2_hit = cdb_valid && !disp_src2_rdy && (cdb_tag == disp_src2_tag);
    assign w_disp1_val = w_disp1_hit ? cdb_data : disp_src1_val;
    assign w_disp2_val = w_disp2_hit ? cdb_data : disp_src2_val;

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_busy[g]     <= 1'b0;
                    r_src1_rdy[g] <= 1'b0;
                    r_src2_rdy[g] <= 1'b0;
                    r_op[g]       <= '0;
                    r_dst_tag[g]  <= '0;
                    r_src1_tag[g] <= '0;
                    r_src2_tag[g] <= '0;
                    r_src1_val[g] <= '0;
                    r_src2_val[g] <= '0;
                end else if (flush) begin
                    r_busy[g] <= 1'b0;
                end else if (slot_wr[g] && !r_busy[g]) begin
                    r_busy[g]     <= 1'b1;
                    r_op[g]       <= disp_op;
                    r_dst_tag[g]  <= disp_dst_tag;
                    r_src1_rdy[g] <= disp_src1_rdy || w_disp1_hit;
                    r_src1_tag[g] <= disp_src1_tag;
                    r_src1_val[g] <= w_disp1_val;
                    r_src2_rdy[g] <= disp_src2_rdy || w_disp2_hit;
                    r_src2_tag[g] <= disp_src2_tag;
                    r_src2_val[g] <= w_disp2_val;
                end else if (r_busy[g]) begin
                    if (w_take[g]) begin
                        r_busy[g] <= 1'b0;
                    end
                    if (cdb_valid && !r_src1_rdy[g] && (cdb_tag == r_src1_tag[g])) begin
                        r_src1_rdy[g] <= 1'b1;
                        r_src1_val[g] <= cdb_data;
                    end
                    if (cdb_valid && !r_src2_rdy[g] && (cdb_tag == r_src2_tag[g])) begin
                        r_src2_rdy[g] <= 1'b1;
                        r_src2_val[g] <= cdb_data;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_valid   <= 1'b0;
            r_issue_op      <= '0;
            r_issue_a       <= '0;
            r_issue_b       <= '0;
            r_issue_dst_tag <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_cand_found) begin
                r_issue_valid   <= 1'b1;
                r_issue_op      <= r_op[w_cand_idx];
                r_issue_a       <= r_src1_val[w_cand_idx];
                r_issue_b       <= r_src2_val[w_cand_idx];
                r_issue_dst_tag <= r_dst_tag[w_cand_idx];
            end else begin
                r_issue_valid <= 1'b0;
            end
        end
    end

    assign slot_busy     = r_busy;
    assign issue_valid   = r_issue_valid;
    assign issue_op      = r_issue_op;
    assign issue_a       = r_issue_a;
    assign issue_b       = r_issue_b;
    assign issue_dst_tag = r_issue_dst_tag;

`ifndef SYNTHESIS
    a_slot_wr_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(slot_wr))
        else $error("slot_wr is multi-hot: %b", slot_wr);
    a_slot_wr_free: assert property (@(posedge clk) disable iff (rst) ((slot_wr & r_busy) == '0))
        else $error("slot_wr targets busy slot: wr=%b busy=%b", slot_wr, r_busy);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_slot_array.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rs_slot_array: directed scenarios plus random traffic vs. a model      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rs_slot_array;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int OW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [NS-1:0] slot_wr;
    logic [OW-1:0] disp_op;
    logic [TW-1:0] disp_dst_tag;
    logic          disp_src1_rdy;
    logic [TW-1:0] disp_src1_tag;
    logic [DW-1:0] disp_src1_val;
    logic          disp_src2_rdy;
    logic [TW-1:0] disp_src2_tag;
    logic [DW-1:0] disp_src2_val;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic [NS-1:0] slot_busy;
    logic          issue_valid;
    logic          issue_ready;
    logic [OW-1:0] issue_op;
    logic [DW-1:0] issue_a;
    logic [DW-1:0] issue_b;
    logic [TW-1:0] issue_dst_tag;

    always #5 clk = ~clk;

    rs_slot_array #(.NUM_SLOTS(NS), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .OP_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .slot_wr(slot_wr),
        .disp_op(disp_op), .disp_dst_tag(disp_dst_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
        .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .slot_busy(slot_busy), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b), .issue_dst_tag(issue_dst_tag)
    );

    // Reference model: one record per entry plus the instruction held at the FU port.
    typedef struct packed {
        logic          busy;
        logic [OW-1:0] op;
        logic [TW-1:0] dst;
        logic          r1;
        logic [TW-1:0] t1;
        logic [DW-1:0] v1;
        logic          r2;
        logic [TW-1:0] t2;
        logic [DW-1:0] v2;
    } slot_t;

    slot_t         m [NS];
    logic          m_iv;
    logic [OW-1:0] m_op;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    logic [TW-1:0] m_dst;

    int total = 0;
    int bad   = 0;

    function automatic logic [NS-1:0] m_busy();
        logic [NS-1:0] b;
        for (int i = 0; i < NS; i++) b[i] = m[i].busy;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m[i] = '0;
        m_iv = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_dst = '0;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; slot_wr = '0; disp_op = '0; disp_dst_tag = '0;
        disp_src1_rdy = 1'b0; disp_src1_tag = '0; disp_src1_val = '0;
        disp_src2_rdy = 1'b0; disp_src2_tag = '0; disp_src2_val = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_disp(input int s, input logic [OW-1:0] op, input logic [TW-1:0] dst,
                            input logic r1, input logic [TW-1:0] t1, input logic [DW-1:0] v1,
                            input logic r2, input logic [TW-1:0] t2, input logic [DW-1:0] v2);
        slot_wr = '0; slot_wr[s] = 1'b1;
        disp_op = op; disp_dst_tag = dst;
        disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
        disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    endtask

    // Advance one clock: predict from the pre-edge state and inputs, then commit.
    task automatic step();
        slot_t nx [NS];
        logic  niv;
        logic  adv;
        int    cand;
        for (int i = 0; i < NS; i++) nx[i] = m[i];
        niv = m_iv;
        if (flush) begin
            for (int i = 0; i < NS; i++) nx[i].busy = 1'b0;
            niv = 1'b0;
        end else begin
            adv  = !m_iv || issue_ready;
            cand = -1;
            for (int i = 0; i < NS; i++)
                if (cand < 0 && m[i].busy && m[i].r1 && m[i].r2) cand = i;
            for (int i = 0; i < NS; i++) begin
                if (m[i].busy) begin
                    if (cdb_valid && !m[i].r1 && m[i].t1 == cdb_tag) begin nx[i].r1 = 1'b1; nx[i].v1 = cdb_data; end
                    if (cdb_valid && !m[i].r2 && m[i].t2 == cdb_tag) begin nx[i].r2 = 1'b1; nx[i].v2 = cdb_data; end
                end else if (slot_wr[i]) begin
                    nx[i].busy = 1'b1; nx[i].op = disp_op; nx[i].dst = disp_dst_tag;
                    nx[i].r1 = disp_src1_rdy; nx[i].t1 = disp_src1_tag; nx[i].v1 = disp_src1_val;
                    nx[i].r2 = disp_src2_rdy; nx[i].t2 = disp_src2_tag; nx[i].v2 = disp_src2_val;
                    if (!disp_src1_rdy && cdb_valid && cdb_tag == disp_src1_tag) begin nx[i].r1 = 1'b1; nx[i].v1 = cdb_data; end
                    if (!disp_src2_rdy && cdb_valid && cdb_tag == disp_src2_tag) begin nx[i].r2 = 1'b1; nx[i].v2 = cdb_data; end
                end
            end
            if (adv) begin
                if (cand >= 0) begin
                    niv = 1'b1;
                    m_op = m[cand].op; m_a = m[cand].v1; m_b = m[cand].v2; m_dst = m[cand].dst;
                    nx[cand].busy = 1'b0;
                end else begin
                    niv = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) m[i] = nx[i];
        m_iv = niv;
    endtask

    task automatic do_reset();
        idle_inputs();
        issue_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        issue_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (slot_busy !== 8'h00) begin bad++; $display("FAIL reset_busy: got %h want 00", slot_busy); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", issue_valid); end
        total++; if ({issue_op, issue_a, issue_b, issue_dst_tag} !== '0) begin
            bad++; $display("FAIL reset_data: op=%h a=%h b=%h dst=%h want all 0", issue_op, issue_a, issue_b, issue_dst_tag);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ready_dispatch();
        issue_ready = 1'b1;
        set_disp(0, 5'd2, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        step();
        idle_inputs();
        total++; if (slot_busy !== 8'h01 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL ready_write_edge: busy=%h valid=%b want 01/0", slot_busy, issue_valid);
        end
        step();
        total++; if (issue_valid !== 1'b1 || issue_a !== 32'd5 || issue_b !== 32'd7 || issue_dst_tag !== 4'd3 || issue_op !== 5'd2) begin
            bad++; $display("FAIL ready_issue: v=%b a=%h b=%h dst=%h op=%h want 1/5/7/3/2", issue_valid, issue_a, issue_b, issue_dst_tag, issue_op);
        end
        total++; if (slot_busy !== 8'h00) begin bad++; $display("FAIL ready_freed: busy=%h want 00", slot_busy); end
        step();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL ready_drain: valid=%b want 0", issue_valid); end
    endtask

    task automatic test_wakeup();
        issue_ready = 1'b1;
        set_disp(2, 5'd4, 4'd6, 1'b1, 4'd0, 32'd1, 1'b0, 4'd9, 32'd0);
        step();
        idle_inputs();
        step();
        cdb_valid = 1'b1; cdb_tag = 4'd8; cdb_data = 32'h55;
        step();
        total++; if (slot_busy !== 8'h04 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL wake_wrong_tag: busy=%h valid=%b want 04/0", slot_busy, issue_valid);
        end
        cdb_tag = 4'd9; cdb_data = 32'hAB;
        step();
        cdb_valid = 1'b0;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_same_cycle: valid=%b want 0", issue_valid); end
        step();
        total++; if (issue_valid !== 1'b1 || issue_b !== 32'hAB || issue_a !== 32'd1 || issue_dst_tag !== 4'd6 || slot_busy !== 8'h00) begin
            bad++; $display("FAIL wake_issue: v=%b a=%h b=%h dst=%h busy=%h want 1/1/ab/6/00", issue_valid, issue_a, issue_b, issue_dst_tag, slot_busy);
        end
        step();
    endtask

    task automatic test_bypass();
        issue_ready = 1'b1;
        set_disp(3, 5'd7, 4'd2, 1'b0, 4'd4, 32'hDEAD, 1'b1, 4'd0, 32'h22);
        cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_data = 32'h11;
        step();
        idle_inputs();
        step();
        total++; if (issue_valid !== 1'b1 || issue_a !== 32'h11 || issue_b !== 32'h22 || issue_dst_tag !== 4'd2) begin
            bad++; $display("FAIL bypass_issue: v=%b a=%h b=%h dst=%h want 1/11/22/2", issue_valid, issue_a, issue_b, issue_dst_tag);
        end
        step();
    endtask

    task automatic test_backpressure();
        issue_ready = 1'b0;
        set_disp(1, 5'd1, 4'd1, 1'b1, 4'd0, 32'h10, 1'b1, 4'd0, 32'h11);
        step();
        set_disp(5, 5'd5, 4'd5, 1'b1, 4'd0, 32'h50, 1'b1, 4'd0, 32'h51);
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (issue_valid !== 1'b1 || issue_dst_tag !== 4'd1 || issue_a !== 32'h10 || issue_b !== 32'h11 || slot_busy !== 8'h20) begin
                bad++; $display("FAIL bp_hold%0d: v=%b dst=%h a=%h b=%h busy=%h want 1/1/10/11/20", c, issue_valid, issue_dst_tag, issue_a, issue_b, slot_busy);
            end
        end
        issue_ready = 1'b1;
        step();
        total++; if (issue_valid !== 1'b1 || issue_dst_tag !== 4'd5 || issue_a !== 32'h50 || slot_busy !== 8'h00) begin
            bad++; $display("FAIL bp_second: v=%b dst=%h a=%h busy=%h want 1/5/50/00", issue_valid, issue_dst_tag, issue_a, slot_busy);
        end
        step();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: valid=%b want 0", issue_valid); end
    endtask

    task automatic test_full_array();
        do_reset();
        for (int i = 0; i < NS; i++) begin
            set_disp(i, OW'(i), TW'(i), 1'b0, TW'(i), 32'd0, 1'b1, 4'd0, 32'd100 + i);
            step();
        end
        idle_inputs();
        total++; if (slot_busy !== 8'hFF || issue_valid !== 1'b0) begin
            bad++; $display("FAIL full_fill: busy=%h valid=%b want ff/0", slot_busy, issue_valid);
        end
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h66;
        step();
        idle_inputs();
        step();
        total++; if (issue_valid !== 1'b1 || issue_dst_tag !== 4'd6 || issue_a !== 32'h66 || issue_b !== 32'd106 || slot_busy !== 8'hBF) begin
            bad++; $display("FAIL full_wake6: v=%b dst=%h a=%h b=%h busy=%h want 1/6/66/6a/bf", issue_valid, issue_dst_tag, issue_a, issue_b, slot_busy);
        end
    endtask

    task automatic test_flush();
        do_reset();
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_disp(i, 5'd3, TW'(i), 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
            step();
        end
        idle_inputs();
        total++; if (slot_busy !== 8'h1E || issue_valid !== 1'b1) begin
            bad++; $display("FAIL flush_setup: busy=%h valid=%b want 1e/1", slot_busy, issue_valid);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (slot_busy !== 8'h00 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL flush_clear: busy=%h valid=%b want 00/0", slot_busy, issue_valid);
        end
        issue_ready = 1'b1;
        step();
        total++; if (slot_busy !== 8'h00 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL flush_after: busy=%h valid=%b want 00/0", slot_busy, issue_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_ready = 1'b0;
        set_disp(0, 5'd9, 4'd7, 1'b1, 4'd0, 32'h21, 1'b1, 4'd0, 32'h22);
        step();
        set_disp(1, 5'd9, 4'd8, 1'b0, 4'd3, 32'h0, 1'b1, 4'd0, 32'h23);
        step();
        idle_inputs();
        total++; if (issue_valid !== 1'b1 || issue_a !== 32'h21 || slot_busy !== 8'h02) begin
            bad++; $display("FAIL arst_setup: v=%b a=%h busy=%h want 1/21/02", issue_valid, issue_a, slot_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (slot_busy !== 8'h00 || issue_valid !== 1'b0 || issue_a !== 32'h0 || issue_dst_tag !== 4'h0) begin
            bad++; $display("FAIL arst_immediate: busy=%h v=%b a=%h dst=%h want 00/0/0/0", slot_busy, issue_valid, issue_a, issue_dst_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        issue_ready = 1'b1;
    endtask

    task automatic test_random();
        int free_q[$];
        int s;
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            issue_ready = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            cdb_valid   = ($urandom_range(0, 1) == 1);
            cdb_tag     = TW'($urandom_range(0, 7));
            cdb_data    = $urandom;
            if ($urandom_range(0, 9) < 6) begin
                free_q.delete();
                for (int i = 0; i < NS; i++) if (!m[i].busy) free_q.push_back(i);
                if (free_q.size() > 0) begin
                    s = free_q[$urandom_range(0, free_q.size() - 1)];
                    set_disp(s, OW'($urandom), TW'($urandom),
                             ($urandom_range(0, 1) == 1), TW'($urandom_range(0, 7)), $urandom,
                             ($urandom_range(0, 1) == 1), TW'($urandom_range(0, 7)), $urandom);
                end
            end
            step();
            total++; if (slot_busy !== m_busy()) begin
                bad++; $display("FAIL rand_busy c=%0d: got %h want %h", c, slot_busy, m_busy());
            end
            total++; if (issue_valid !== m_iv) begin
                bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, issue_valid, m_iv);
            end
            if (m_iv) begin
                total++; if ({issue_op, issue_a, issue_b, issue_dst_tag} !== {m_op, m_a, m_b, m_dst}) begin
                    bad++; $display("FAIL rand_payload c=%0d: got op=%h a=%h b=%h dst=%h want op=%h a=%h b=%h dst=%h",
                                    c, issue_op, issue_a, issue_b, issue_dst_tag, m_op, m_a, m_b, m_dst);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        issue_ready = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_bypass();
        test_backpressure();
        test_full_array();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
